wb_host_master: RTL and testbench

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_master_if.sv | 46 ++++
 rtl/wb_host_master.sv | 110 +++++++++++
 tb/tb_wb_host_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_host_master_if.sv
// Command/response handshake plus Wishbone initiator signals of wb_host_master.
// The master modport is the DUT's view; slave is the host/responder side.
interface wb_host_master_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic                 Cmd_Valid_i;
  logic                 Cmd_Ready_o;
  logic [ADDRWIDTH-1:0] Cmd_Adr_i;
  logic                 Cmd_WE_i;
  logic [3:0]           Cmd_BYTE_STB_i;
  logic [DATAWIDTH-1:0] Cmd_Dat_i;

  logic                 Rsp_Valid_o;
  logic                 Rsp_Ready_i;
  logic [DATAWIDTH-1:0] Rsp_Dat_o;
  logic                 Rsp_Err_o;

  logic [ADDRWIDTH-1:0] WBm_ADR_o;
  logic                 WBm_CYC_o;
  logic                 WBm_STB_o;
  logic                 WBm_WE_o;
  logic                 WBm_RD_o;
  logic [3:0]           WBm_BYTE_STB_o;
  logic [DATAWIDTH-1:0] WBm_WR_DAT_o;
  logic [DATAWIDTH-1:0] WBm_RD_DAT_i;
  logic                 WBm_ACK_i;

  logic                 Busy_o;

  modport master (
    input  Cmd_Valid_i, Cmd_Adr_i, Cmd_WE_i, Cmd_BYTE_STB_i, Cmd_Dat_i,
    input  Rsp_Ready_i, WBm_RD_DAT_i, WBm_ACK_i,
    output Cmd_Ready_o, Rsp_Valid_o, Rsp_Dat_o, Rsp_Err_o,
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    output WBm_BYTE_STB_o, WBm_WR_DAT_o, Busy_o
  );

  modport slave (
    output Cmd_Valid_i, Cmd_Adr_i, Cmd_WE_i, Cmd_BYTE_STB_i, Cmd_Dat_i,
    output Rsp_Ready_i, WBm_RD_DAT_i, WBm_ACK_i,
    input  Cmd_Ready_o, Rsp_Valid_o, Rsp_Dat_o, Rsp_Err_o,
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o,
    input  WBm_BYTE_STB_o, WBm_WR_DAT_o, Busy_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone initiator: a host command becomes one bus cycle,
// abandoned after a bounded ACK wait, and its result is returned as a response.
module wb_host_master #(
  parameter int                      ADDRWIDTH          = 17,
  parameter int                      DATAWIDTH          = 32,
  parameter int                      TIMEOUT_CNTR_WIDTH = 4,
  parameter int                      TIMEOUT_CNTR_LIMIT = 15,
  parameter logic [DATAWIDTH-1:0]    DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input logic               WBs_CLK_i,
  input logic               WBs_RST_n_i,
  wb_host_master_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LIMIT =
    TIMEOUT_CNTR_WIDTH'(TIMEOUT_CNTR_LIMIT);
  localparam logic [ADDRWIDTH-1:0] ADR_MASK = ~ADDRWIDTH'(3);

  logic [1:0]                    r_state;
  logic [TIMEOUT_CNTR_WIDTH-1:0] r_cnt;
  logic                          r_cyc;
  logic                          r_stb;
  logic                          r_we;
  logic                          r_rd;
  logic [ADDRWIDTH-1:0]          r_adr;
  logic [3:0]                    r_byteStb;
  logic [DATAWIDTH-1:0]          r_wrDat;
  logic [DATAWIDTH-1:0]          r_rspDat;
  logic                          r_rspErr;

  logic [ADDRWIDTH-1:0]          w_adrAligned;
  logic                          w_timeout;

  assign w_adrAligned = bus.Cmd_Adr_i & ADR_MASK;
  assign w_timeout    = (r_cnt == CNT_LIMIT);

  // ACK has priority over the timeout, so a reply on the last wait cycle still completes normally
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_rd      <= 1'b0;
      r_adr     <= '0;
      r_byteStb <= '0;
      r_wrDat   <= '0;
      r_rspDat  <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Cmd_Valid_i) begin
            r_state   <= BUS;
            r_cnt     <= '0;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_we      <= bus.Cmd_WE_i;
            r_rd      <= ~bus.Cmd_WE_i;
            r_adr     <= w_adrAligned;
            r_byteStb <= bus.Cmd_BYTE_STB_i;
            r_wrDat   <= bus.Cmd_WE_i ? bus.Cmd_Dat_i : '0;
          end
        end
        BUS: begin
          if (bus.WBm_ACK_i || w_timeout) begin
            r_state  <= RESP;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= 1'b0;
            r_rspErr <= ~bus.WBm_ACK_i;
            if (r_we)
              r_rspDat <= '0;
            else if (bus.WBm_ACK_i)
              r_rspDat <= bus.WBm_RD_DAT_i;
            else
              r_rspDat <= DEFAULT_READ_VALUE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.Rsp_Ready_i)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Cmd_Ready_o    = (r_state == IDLE);
  assign bus.Busy_o         = (r_state != IDLE);
  assign bus.Rsp_Valid_o    = (r_state == RESP);
  assign bus.Rsp_Dat_o      = r_rspDat;
  assign bus.Rsp_Err_o      = r_rspErr;
  assign bus.WBm_ADR_o      = r_adr;
  assign bus.WBm_CYC_o      = r_cyc;
  assign bus.WBm_STB_o      = r_stb;
  assign bus.WBm_WE_o       = r_we;
  assign bus.WBm_RD_o       = r_rd;
  assign bus.WBm_BYTE_STB_o = r_byteStb;
  assign bus.WBm_WR_DAT_o   = r_wrDat;

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master: directed commands push expected responses,
// a monitor pops them on every response handshake, a responder models the slave.
module tb_wb_host_master;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst_n;

  wb_host_master_if #(.ADDRWIDTH(17), .DATAWIDTH(32)) bus ();

  wb_host_master dut (
    .WBs_CLK_i   (clk),
    .WBs_RST_n_i (rst_n),
    .bus         (bus)
  );

  int   nChecks = 0;
  int   nFails  = 0;
  rsp_t expQ[$];

  int          ackDelay    = -1;
  logic [31:0] rdData      = 32'h0;
  bit          forceAck    = 1'b0;
  int          cycCnt      = 0;
  int          lastCycLen  = 0;
  logic [54:0] busSnap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: ACKs in the CYC cycle numbered ackDelay (0 = first), never if negative
  initial begin
    bus.WBm_ACK_i    = 1'b0;
    bus.WBm_RD_DAT_i = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.WBm_CYC_o) begin
        if (cycCnt == 0)
          busSnap = {bus.WBm_ADR_o, bus.WBm_WE_o, bus.WBm_RD_o, bus.WBm_BYTE_STB_o, bus.WBm_WR_DAT_o};
        else
          checkOutput("busStable",
                      {9'd0, bus.WBm_ADR_o, bus.WBm_WE_o, bus.WBm_RD_o, bus.WBm_BYTE_STB_o, bus.WBm_WR_DAT_o},
                      {9'd0, busSnap});
        bus.WBm_ACK_i    = forceAck || (cycCnt == ackDelay);
        bus.WBm_RD_DAT_i = (cycCnt == ackDelay) ? rdData : 32'hDEAD_0000 + cycCnt;
        cycCnt++;
      end else begin
        if (cycCnt != 0)
          lastCycLen = cycCnt;
        cycCnt           = 0;
        bus.WBm_ACK_i    = forceAck;
        bus.WBm_RD_DAT_i = 32'h0;
      end
    end
  end

  // Scoreboard monitor: every accepted response must match the oldest expectation
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.Rsp_Valid_o && bus.Rsp_Ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRsp", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rspDat", {32'd0, bus.Rsp_Dat_o}, {32'd0, e.dat});
          checkOutput("rspErr", {63'd0, bus.Rsp_Err_o}, {63'd0, e.err});
        end
      end
    end
  end

  // Presents a command and returns at the negedge after the accepting edge
  task automatic issueCmd(input bit we, input logic [16:0] adr, input logic [3:0] bstb,
                          input logic [31:0] dat);
    int t;
    bus.Cmd_Valid_i    = 1'b1;
    bus.Cmd_WE_i       = we;
    bus.Cmd_Adr_i      = adr;
    bus.Cmd_BYTE_STB_i = bstb;
    bus.Cmd_Dat_i      = dat;
    t = 0;
    while (!bus.Cmd_Ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("cmdAccept", {63'd0, bus.Cmd_Ready_o}, 64'd1);
    @(negedge clk);
    bus.Cmd_Valid_i = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 1;
    while (!bus.Rsp_Valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [16:0] adr, input logic [3:0] bstb,
                               input logic [31:0] dat, input int ackDly, input logic [31:0] rdDat,
                               input logic [31:0] expDat, input bit expErr);
    int lat;
    int expLat;
    int expCyc;
    expLat   = (ackDly < 0) ? 17 : ackDly + 2;
    expCyc   = (ackDly < 0) ? 16 : ackDly + 1;
    ackDelay = ackDly;
    rdData   = rdDat;
    expQ.push_back('{dat: expDat, err: expErr});
    issueCmd(we, adr, bstb, dat);
    checkOutput("cycHigh", {63'd0, bus.WBm_CYC_o}, 64'd1);
    checkOutput("stbHigh", {63'd0, bus.WBm_STB_o}, 64'd1);
    checkOutput("adr", {47'd0, bus.WBm_ADR_o}, {47'd0, adr[16:2], 2'b00});
    checkOutput("we", {63'd0, bus.WBm_WE_o}, {63'd0, we});
    checkOutput("rd", {63'd0, bus.WBm_RD_o}, {63'd0, ~we});
    checkOutput("byteStb", {60'd0, bus.WBm_BYTE_STB_o}, {60'd0, bstb});
    checkOutput("wrDat", {32'd0, bus.WBm_WR_DAT_o}, {32'd0, (we ? dat : 32'h0)});
    checkOutput("busy", {63'd0, bus.Busy_o}, 64'd1);
    checkOutput("readyLow", {63'd0, bus.Cmd_Ready_o}, 64'd0);
    waitRsp(lat);
    checkOutput("latency", 64'(lat), 64'(expLat));
    @(negedge clk);
    checkOutput("cycLength", 64'(lastCycLen), 64'(expCyc));
  endtask

  initial begin
    int lat;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_n              = 1'b0;
    bus.Cmd_Valid_i    = 1'b0;
    bus.Cmd_WE_i       = 1'b0;
    bus.Cmd_Adr_i      = '0;
    bus.Cmd_BYTE_STB_i = '0;
    bus.Cmd_Dat_i      = '0;
    bus.Rsp_Ready_i    = 1'b1;
    #12;
    checkOutput("rstReady", {63'd0, bus.Cmd_Ready_o}, 64'd1);
    checkOutput("rstCyc", {63'd0, bus.WBm_CYC_o}, 64'd0);
    checkOutput("rstBusy", {63'd0, bus.Busy_o}, 64'd0);
    checkOutput("rstRspValid", {63'd0, bus.Rsp_Valid_o}, 64'd0);
    checkOutput("rstAdr", {47'd0, bus.WBm_ADR_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 17'h01004, 4'h1, 32'h0000_00A5, 0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 17'h00007, 4'hF, 32'hFFFF_FFFF, 2, 32'h1234_5678, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 17'h1FFF3, 4'hF, 32'h0, -1, 32'h0, 32'hBAD_FAB_AC, 1'b1);
    applyStimulus(1'b0, 17'h00010, 4'h3, 32'h0, 15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, 17'h00020, 4'hC, 32'h5555_AAAA, -1, 32'h0, 32'h0, 1'b1);

    // Response back-pressure with a second command already waiting
    bus.Rsp_Ready_i = 1'b0;
    ackDelay = 1;
    rdData   = 32'h0F0F_0F0F;
    expQ.push_back('{dat: 32'h0F0F_0F0F, err: 1'b0});
    issueCmd(1'b0, 17'h00100, 4'hF, 32'h0);
    waitRsp(lat);
    checkOutput("stallLatency", 64'(lat), 64'd3);
    ackDelay = 0;
    forceAck = 1'b1;
    bus.Cmd_Valid_i    = 1'b1;
    bus.Cmd_WE_i       = 1'b1;
    bus.Cmd_Adr_i      = 17'h00200;
    bus.Cmd_BYTE_STB_i = 4'hF;
    bus.Cmd_Dat_i      = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallValid", {63'd0, bus.Rsp_Valid_o}, 64'd1);
      checkOutput("stallDat", {32'd0, bus.Rsp_Dat_o}, 64'h0F0F_0F0F);
      checkOutput("stallErr", {63'd0, bus.Rsp_Err_o}, 64'd0);
      checkOutput("stallReady", {63'd0, bus.Cmd_Ready_o}, 64'd0);
      checkOutput("stallCyc", {63'd0, bus.WBm_CYC_o}, 64'd0);
    end
    expQ.push_back('{dat: 32'h0, err: 1'b0});
    bus.Rsp_Ready_i = 1'b1;
    forceAck = 1'b0;
    @(negedge clk);
    checkOutput("postHsReady", {63'd0, bus.Cmd_Ready_o}, 64'd1);
    checkOutput("postHsCyc", {63'd0, bus.WBm_CYC_o}, 64'd0);
    @(negedge clk);
    bus.Cmd_Valid_i = 1'b0;
    checkOutput("secondCyc", {63'd0, bus.WBm_CYC_o}, 64'd1);
    checkOutput("secondWe", {63'd0, bus.WBm_WE_o}, 64'd1);
    checkOutput("secondAdr", {47'd0, bus.WBm_ADR_o}, 64'h00200);
    waitRsp(lat);
    checkOutput("secondLatency", 64'(lat), 64'd2);
    @(negedge clk);

    // Reset in the second CYC cycle of a read aborts it without a response
    ackDelay = -1;
    issueCmd(1'b0, 17'h00300, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("abortCycBefore", {63'd0, bus.WBm_CYC_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortCyc", {63'd0, bus.WBm_CYC_o}, 64'd0);
    checkOutput("abortStb", {63'd0, bus.WBm_STB_o}, 64'd0);
    checkOutput("abortBusy", {63'd0, bus.Busy_o}, 64'd0);
    checkOutput("abortReady", {63'd0, bus.Cmd_Ready_o}, 64'd1);
    checkOutput("abortRspValid", {63'd0, bus.Rsp_Valid_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Rsp_Valid_o)
        checkOutput("abortNoRsp", {63'd0, bus.Rsp_Valid_o}, 64'd0);
    end
    checkOutput("abortIdleBusy", {63'd0, bus.Busy_o}, 64'd0);
    applyStimulus(1'b1, 17'h01008, 4'h6, 32'h8765_4321, 1, 32'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
